// File: rtl/pmc_pkg.sv
// Shared types for the PMC controller blocks.
// owner_e tags which master owns the RAM response that is in flight.
package pmc_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_M0   = 2'd1,
        OWNER_M1   = 2'd2
    } owner_e;

    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/ibex_data_bus.sv
// Ibex-style data bus: request/grant handshake with a one-cycle-later response.
// The master drives the request fields; the slave drives grant and response.
interface ibex_data_bus;

    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [6:0]  wdata_intg;
    logic [31:0] rdata;
    logic [6:0]  rdata_intg;
    logic        err;

    modport master (
        output req, we, be, addr, wdata, wdata_intg,
        input  gnt, rvalid, rdata, rdata_intg, err
    );

    modport slave (
        input  req, we, be, addr, wdata, wdata_intg,
        output gnt, rvalid, rdata, rdata_intg, err
    );

endinterface

// File: rtl/pmcc_code_ram_arbiter.sv
// Two-master arbiter for the PMC code RAM data port: m0 (core) preferred,
// m1 (host loader) protected by a starvation counter and an exclusive-access input.
module pmcc_code_ram_arbiter
    import pmc_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    ibex_data_bus.slave  m0_bus,
    ibex_data_bus.slave  m1_bus,
    ibex_data_bus.master ram_bus,
    input  logic         host_excl,
    output logic         m0_stalled
);

    localparam logic [STARVE_W-1:0] LP_LIMIT = STARVE_W'(STARVE_LIMIT);

    owner_e              w_winner;
    owner_e              r_owner_q;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_m0_stalled;
    logic                w_m0_gnt;
    logic                w_m1_gnt;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_winner = OWNER_NONE;
        if (host_excl) begin
            if (m1_bus.req) w_winner = OWNER_M1;
        end else if (m1_bus.req && (r_starve_cnt == LP_LIMIT)) begin
            w_winner = OWNER_M1;
        end else if (m0_bus.req) begin
            w_winner = OWNER_M0;
        end else if (m1_bus.req) begin
            w_winner = OWNER_M1;
        end
    end

    always_comb begin
        ram_bus.req        = 1'b0;
        ram_bus.we         = 1'b0;
        ram_bus.be         = '0;
        ram_bus.addr       = '0;
        ram_bus.wdata      = '0;
        ram_bus.wdata_intg = '0;
        case (w_winner)
            OWNER_M0: begin
                ram_bus.req        = 1'b1;
                ram_bus.we         = m0_bus.we;
                ram_bus.be         = m0_bus.be;
                ram_bus.addr       = m0_bus.addr;
                ram_bus.wdata      = m0_bus.wdata;
                ram_bus.wdata_intg = m0_bus.wdata_intg;
            end
            OWNER_M1: begin
                ram_bus.req        = 1'b1;
                ram_bus.we         = m1_bus.we;
                ram_bus.be         = m1_bus.be;
                ram_bus.addr       = m1_bus.addr;
                ram_bus.wdata      = m1_bus.wdata;
                ram_bus.wdata_intg = m1_bus.wdata_intg;
            end
            default: ;
        endcase
    end

    assign w_m0_gnt   = (w_winner == OWNER_M0) & ram_bus.gnt;
    assign w_m1_gnt   = (w_winner == OWNER_M1) & ram_bus.gnt;
    assign m0_bus.gnt = w_m0_gnt;
    assign m1_bus.gnt = w_m1_gnt;

    // Responses are steered by the owner of last cycle's grant; a response landing
    // during reset or with no owner is dropped.
    assign m0_bus.rvalid     = ram_bus.rvalid & ~rst & (r_owner_q == OWNER_M0);
    assign m1_bus.rvalid     = ram_bus.rvalid & ~rst & (r_owner_q == OWNER_M1);
    assign m0_bus.rdata      = ram_bus.rdata;
    assign m1_bus.rdata      = ram_bus.rdata;
    assign m0_bus.rdata_intg = ram_bus.rdata_intg;
    assign m1_bus.rdata_intg = ram_bus.rdata_intg;
    assign m0_bus.err        = ram_bus.err;
    assign m1_bus.err        = ram_bus.err;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_q    <= OWNER_NONE;
            r_starve_cnt <= '0;
            r_m0_stalled <= 1'b0;
        end else begin
            r_owner_q <= w_m0_gnt ? OWNER_M0 : (w_m1_gnt ? OWNER_M1 : OWNER_NONE);
            if (!m1_bus.req || w_m1_gnt) begin
                r_starve_cnt <= '0;
            end else if (w_m0_gnt && (r_starve_cnt != LP_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            r_m0_stalled <= m0_bus.req & ~w_m0_gnt;
        end
    end

    assign m0_stalled = r_m0_stalled;

endmodule

// File: tb/tb_pmcc_code_ram_arbiter.sv
// Self-checking bench for pmcc_code_ram_arbiter: reset-time arbitration table,
// directed multi-cycle sequences, and randomized traffic against a cycle model.
module tb_pmcc_code_ram_arbiter;
    import pmc_pkg::*;

    localparam int unsigned LIMIT = 4;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        bit          m0_req;
        bit          m1_req;
        bit          excl;
        bit          e_g0;
        bit          e_g1;
        logic [31:0] e_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic host_excl;
    logic m0_stalled;
    logic mem_clr;

    ibex_data_bus m0_if ();
    ibex_data_bus m1_if ();
    ibex_data_bus ram_if ();

    pmcc_code_ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_bus     (m0_if),
        .m1_bus     (m1_if),
        .ram_bus    (ram_if),
        .host_excl  (host_excl),
        .m0_stalled (m0_stalled)
    );

    always #5 clk = ~clk;

    // Code RAM model: grants whatever it is asked, answers one cycle later.
    logic [31:0] ram_mem [64];
    assign ram_if.gnt        = ram_if.req;
    assign ram_if.rdata_intg = 7'h0;
    assign ram_if.err        = 1'b0;
    always @(posedge clk) begin
        ram_if.rvalid <= ram_if.req;
        ram_if.rdata  <= ram_mem[ram_if.addr[7:2]];
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= '0;
        end else if (ram_if.req && ram_if.we) begin
            ram_mem[ram_if.addr[7:2]] <= ram_if.wdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_owner;     // 0 none, 1 m0, 2 m1: who was granted last cycle
    int          m_wait;      // cycles m1 has waited behind m0 grants
    bit          m_stalled;
    bit          m_was_read;
    logic [31:0] m_rdata;
    logic [31:0] m_mem [64];

    // DUT observations of the most recent cycle
    logic        d_g0, d_g1, d_rv0, d_rv1, d_stall;
    logic [31:0] d_rdata;
    bit          last_g0, last_g1;

    function automatic mreq_t mk(input bit req, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        mreq_t p;
        p.req = req; p.we = we; p.addr = addr; p.wdata = wdata;
        return p;
    endfunction

    task automatic drive(input bit r, input bit ex, input mreq_t p0, input mreq_t p1);
        rst = r;
        host_excl = ex;
        m0_if.req = p0.req; m0_if.we = p0.we; m0_if.addr = p0.addr; m0_if.wdata = p0.wdata;
        m1_if.req = p1.req; m1_if.we = p1.we; m1_if.addr = p1.addr; m1_if.wdata = p1.wdata;
        m0_if.be = 4'hF; m1_if.be = 4'hF;
        m0_if.wdata_intg = 7'h0; m1_if.wdata_intg = 7'h0;
    endtask

    task automatic cycle(input bit r, input bit ex, input mreq_t p0, input mreq_t p1);
        bit    w0, w1, e_rv0, e_rv1;
        mreq_t pw;
        @(negedge clk);
        drive(r, ex, p0, p1);
        #1;
        w0 = 1'b0;
        w1 = 1'b0;
        if (ex)                              w1 = p1.req;
        else if (p1.req && m_wait >= LIMIT)  w1 = 1'b1;
        else if (p0.req)                     w0 = 1'b1;
        else                                 w1 = p1.req;
        e_rv0 = !r && (m_owner == 1);
        e_rv1 = !r && (m_owner == 2);
        d_g0 = m0_if.gnt; d_g1 = m1_if.gnt;
        d_rv0 = m0_if.rvalid; d_rv1 = m1_if.rvalid;
        d_stall = m0_stalled; d_rdata = m0_if.rdata;
        check("m0_gnt", 32'(d_g0), 32'(w0));
        check("m1_gnt", 32'(d_g1), 32'(w1));
        check("ram_req", 32'(ram_if.req), 32'(w0 | w1));
        check("m0_rvalid", 32'(d_rv0), 32'(e_rv0));
        check("m1_rvalid", 32'(d_rv1), 32'(e_rv1));
        check("m0_stalled", 32'(d_stall), 32'(m_stalled));
        if (e_rv0 && m_was_read) check("m0_rdata", m0_if.rdata, m_rdata);
        if (e_rv1 && m_was_read) check("m1_rdata", m1_if.rdata, m_rdata);
        if (w0 || w1) begin
            pw = w0 ? p0 : p1;
            check("ram_addr", ram_if.addr, pw.addr);
            m_rdata    = m_mem[pw.addr[7:2]];
            m_was_read = !pw.we;
            if (pw.we) m_mem[pw.addr[7:2]] = pw.wdata;
        end
        if (r) begin
            m_owner = 0; m_wait = 0; m_stalled = 1'b0;
        end else begin
            m_owner   = w0 ? 1 : (w1 ? 2 : 0);
            if (!p1.req || w1) m_wait = 0;
            else if (w0 && m_wait < LIMIT) m_wait++;
            m_stalled = p0.req && !w0;
        end
        last_g0 = w0;
        last_g1 = w1;
    endtask

    vec_t  vecs[8];
    mreq_t idle, rp0, rp1;
    bit    r_ex;

    initial begin
        vecs[0] = '{0, 0, 0, 0, 0, 32'h0};
        vecs[1] = '{1, 0, 0, 1, 0, 32'h100};
        vecs[2] = '{0, 1, 0, 0, 1, 32'h200};
        vecs[3] = '{1, 1, 0, 1, 0, 32'h100};
        vecs[4] = '{1, 1, 1, 0, 1, 32'h200};
        vecs[5] = '{1, 0, 1, 0, 0, 32'h0};
        vecs[6] = '{0, 1, 1, 0, 1, 32'h200};
        vecs[7] = '{0, 0, 1, 0, 0, 32'h0};

        idle = mk(0, 0, 0, 0);
        mem_clr = 1'b1;
        drive(1, 0, idle, idle);
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_owner = 0; m_wait = 0; m_stalled = 1'b0; m_was_read = 1'b0; m_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;

        // Arbitration table held under reset: counter is 0, grants still follow req.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1, vecs[i].excl, mk(vecs[i].m0_req, 0, 32'h100, 0),
                  mk(vecs[i].m1_req, 0, 32'h200, 0));
            #1;
            check($sformatf("tbl%0d_m0_gnt", i), 32'(m0_if.gnt), 32'(vecs[i].e_g0));
            check($sformatf("tbl%0d_m1_gnt", i), 32'(m1_if.gnt), 32'(vecs[i].e_g1));
            check($sformatf("tbl%0d_addr", i), ram_if.addr, vecs[i].e_addr);
            check($sformatf("tbl%0d_rv", i), 32'({m0_if.rvalid, m1_if.rvalid}), 32'h0);
            check($sformatf("tbl%0d_stall", i), 32'(m0_stalled), 32'h0);
        end
        cycle(1, 0, idle, idle);
        cycle(0, 0, idle, idle);

        // Single master: m1 writes then reads back.
        cycle(0, 0, idle, mk(1, 1, 32'h10, 32'hDEADBEEF));
        check("sm_wr_gnt", 32'(d_g1), 32'h1);
        cycle(0, 0, idle, mk(1, 0, 32'h10, 0));
        check("sm_rd_gnt", 32'(d_g1), 32'h1);
        cycle(0, 0, idle, idle);
        check("sm_rvalid", 32'(d_rv1), 32'h1);
        check("sm_rdata", d_rdata, 32'hDEADBEEF);
        check("sm_m0_rvalid", 32'(d_rv0), 32'h0);

        // Contention: m1 forced through every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, mk(1, 0, 32'h20, 0), mk(1, 0, 32'h24, 0));
            check($sformatf("cont%0d_m1", i), 32'(d_g1), 32'((i % 5) == 4));
        end
        cycle(0, 0, idle, idle);

        // Alternating owners with distinct data.
        cycle(0, 0, mk(1, 1, 32'h30, 32'hA0A0A0A0), idle);
        cycle(0, 0, idle, mk(1, 1, 32'h34, 32'hB1B1B1B1));
        cycle(0, 0, mk(1, 1, 32'h38, 32'hC2C2C2C2), idle);
        cycle(0, 0, mk(1, 0, 32'h30, 0), idle);
        cycle(0, 0, idle, mk(1, 0, 32'h34, 0));
        check("alt_rv0", 32'(d_rv0), 32'h1);
        check("alt_rd0", d_rdata, 32'hA0A0A0A0);
        cycle(0, 0, mk(1, 0, 32'h38, 0), idle);
        check("alt_rv1", 32'(d_rv1), 32'h1);
        check("alt_rd1", d_rdata, 32'hB1B1B1B1);
        cycle(0, 0, idle, idle);
        check("alt_rv0b", 32'(d_rv0), 32'h1);
        check("alt_rd0b", d_rdata, 32'hC2C2C2C2);

        // Exclusive access locks out m0.
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, mk(1, 0, 32'h40, 0), idle);
            check($sformatf("excl%0d_g0", i), 32'(d_g0), 32'h0);
            check($sformatf("excl%0d_stall", i), 32'(d_stall), 32'(i >= 1));
        end
        cycle(0, 0, mk(1, 0, 32'h40, 0), idle);
        check("excl_release_g0", 32'(d_g0), 32'h1);

        // host_excl raised right after an m0 grant: the response still goes to m0.
        cycle(0, 0, mk(1, 0, 32'h38, 0), idle);
        cycle(0, 1, idle, mk(1, 0, 32'h10, 0));
        check("exr_rv0", 32'(d_rv0), 32'h1);
        check("exr_rd0", d_rdata, 32'hC2C2C2C2);
        check("exr_g1", 32'(d_g1), 32'h1);
        cycle(0, 0, idle, idle);
        check("exr_rv1", 32'(d_rv1), 32'h1);

        // Reset pulsed one cycle after an m0 grant, with the counter part-way up.
        for (int i = 0; i < 3; i++) cycle(0, 0, mk(1, 0, 32'h20, 0), mk(1, 0, 32'h24, 0));
        cycle(1, 0, mk(1, 0, 32'h20, 0), mk(1, 0, 32'h24, 0));
        check("rst_rv0", 32'(d_rv0), 32'h0);
        check("rst_rv1", 32'(d_rv1), 32'h0);
        cycle(0, 0, idle, idle);
        check("rst_after_rv0", 32'(d_rv0), 32'h0);
        check("rst_after_rv1", 32'(d_rv1), 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, mk(1, 0, 32'h20, 0), mk(1, 0, 32'h24, 0));
            check($sformatf("rst_cont%0d_m1", i), 32'(d_g1), 32'(i == 4));
        end

        // Randomized traffic; a master that was not granted holds its request.
        rp0 = idle; rp1 = idle; r_ex = 1'b0;
        last_g0 = 1'b0; last_g1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(rp0.req && !last_g0))
                rp0 = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                         32'($urandom_range(0, 15)) << 2, $urandom);
            if (!(rp1.req && !last_g1))
                rp1 = mk($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                         32'($urandom_range(0, 15)) << 2, $urandom);
            if ($urandom_range(0, 19) == 0) r_ex = !r_ex;
            cycle($urandom_range(0, 59) == 0, r_ex, rp0, rp1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
